blram_initiator: RTL

Memory-side initiator for the FB-CPU's 64×10 block RAM. It accepts single-word write and 1–4-word read-burst requests from the core over a valid/ready handshake and drives the RAM's write-enable, address and data pins. It absorbs the RAM's one-cycle registered read latency and returns read data over a back-pressurable valid/ready response channel. It sits between the core's load/store unit and the RAM instance.

---
 rtl/fb_mem_pkg.sv | 14 +
 rtl/fb_rsp_fifo.sv | 41 ++++
 rtl/blram_initiator.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fb_mem_pkg.sv
// Shared definitions for the FB-CPU block-RAM initiator: data width,
// burst-length width and the initiator state encoding.
package fb_mem_pkg;

    localparam int DW    = 10;
    localparam int LEN_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

endpackage

// File: rtl/fb_rsp_fifo.sv
// Two-entry in-order FIFO holding {last, data} read responses between the
// RAM read port and the back-pressurable response channel.
module fb_rsp_fifo #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] entry [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // NOTE: the two entries are reset too, so rsp_data reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign pop_data = entry[rd_ptr];

endmodule

// File: rtl/blram_initiator.sv
// Memory-side initiator for the FB-CPU 64x10 block RAM: single-word writes,
// 1-4 word read bursts, one-cycle RAM latency absorbed by a 2-entry FIFO.
module blram_initiator #(
    parameter int SIZE  = 6,
    parameter int DEPTH = 64,
    parameter int DW    = fb_mem_pkg::DW
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [SIZE-1:0]              req_addr,
    input  logic [fb_mem_pkg::LEN_W-1:0] req_len,
    input  logic [DW-1:0]                req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DW-1:0]                rsp_data,
    output logic                         rsp_last,
    output logic                         mem_we,
    output logic [SIZE-1:0]              mem_addr,
    output logic [DW-1:0]                mem_wdata,
    input  logic [DW-1:0]                mem_rdata,
    output logic                         busy
);

    import fb_mem_pkg::*;

    state_t            state;
    state_t            state_next;
    logic [LEN_W:0]    beats_left;
    logic              inflight;
    logic              inflight_last;
    logic [SIZE-1:0]   addr_q;
    logic [SIZE-1:0]   addr_inc;
    logic [DW-1:0]     wdata_q;
    logic [1:0]        fifo_count;
    logic [DW:0]       fifo_out;
    logic              accept;
    logic              pop;
    logic              issue;
    logic              drained;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (fifo_count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;

    assign {rsp_last, rsp_data} = fifo_out;

    assign mem_we    = (state == WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign addr_inc = SIZE'((32'(addr_q) + 32'd1) % DEPTH);

    // Issue only if the word it returns is guaranteed a FIFO slot after this cycle's pop.
    assign issue = (state == READ) && (beats_left != '0) &&
                   ((3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop)));

    // Leaving READ one cycle early, as the last word is popped, frees req_ready sooner.
    assign drained = (beats_left == '0) && !inflight &&
                     ((fifo_count - 2'(pop)) == 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_we ? WRITE : READ;
            WRITE:   state_next = IDLE;
            READ:    if (drained) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (beats_left == (LEN_W+1)'(1));
            if (accept) begin
                addr_q     <= req_addr;
                beats_left <= req_we ? '0 : ({1'b0, req_len} + (LEN_W+1)'(1));
                if (req_we) begin
                    wdata_q <= req_wdata;
                end
            end else if (issue) begin
                beats_left <= beats_left - (LEN_W+1)'(1);
                // Hold the final burst address so an idle bus shows the last word read.
                if (beats_left != (LEN_W+1)'(1)) begin
                    addr_q <= addr_inc;
                end
            end
        end
    end

    fb_rsp_fifo #(
        .W (DW + 1)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({inflight_last, mem_rdata}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .count     (fifo_count)
    );

endmodule
